// File: rtl/grid_ram_arbiter.sv
// grid_ram_arbiter
// Shares one single-port, registered-read grid RAM between the processor
// data path (port A, fixed priority) and the display grid scanner (port B).
// An aging counter boosts B after MAX_WAIT consecutive denied cycles, so the
// scanner is always served within a bounded time even under a busy CPU.
// Read data is routed back to the requester whose read was issued one cycle
// earlier, with exactly one cycle of latency.

module grid_ram_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int MAX_WAIT      = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,

  input  logic                     a_req,
  input  logic                     a_we,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_wdata,
  output logic                     a_gnt,
  output logic                     a_rvalid,
  output logic [DATA_WIDTH-1:0]    a_rdata,

  input  logic                     b_req,
  input  logic                     b_we,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_wdata,
  output logic                     b_gnt,
  output logic                     b_rvalid,
  output logic [DATA_WIDTH-1:0]    b_rdata,

  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

  // Arbitration modes: A-first normally, B-first once B has waited too long.
  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_BOOST  = 1'b1;

  // Last value of the aging counter; reaching it while still denied boosts B.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [0:0]               state_q,     state_d;
  logic [7:0]               wait_cnt_q,  wait_cnt_d;
  logic                     a_rd_p1_q,   a_rd_p1_d;
  logic                     b_rd_p1_q,   b_rd_p1_d;
  logic [ADDRESS_WIDTH-1:0] last_addr_q, last_addr_d;

  // Aging counter step: count up by one, holding at WAIT_LAST.
  function automatic logic [7:0] wait_sat_inc(input logic [7:0] cnt);
    if (cnt >= WAIT_LAST) begin
      return WAIT_LAST;
    end
    return cnt + 8'd1;
  endfunction

  // Grant decision: priority order flips in BOOST; nothing is granted in reset.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (reset_n) begin
      if (state_q == ST_BOOST) begin
        b_gnt = b_req;
        a_gnt = a_req & ~b_req;
      end else begin
        a_gnt = a_req;
        b_gnt = b_req & ~a_req;
      end
    end
  end

  // RAM pin drive: winner passes straight through; when idle the address is
  // parked on the last granted one and the resulting read is simply ignored.
  always_comb begin
    ram_wEn    = 1'b0;
    ram_addr   = last_addr_q;
    ram_dataIn = '0;
    if (a_gnt) begin
      ram_wEn    = a_we;
      ram_addr   = a_addr;
      ram_dataIn = a_wdata;
    end else if (b_gnt) begin
      ram_wEn    = b_we;
      ram_addr   = b_addr;
      ram_dataIn = b_wdata;
    end
  end

  // Next-state logic for the mode, the aging counter and the read-owner pipe.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_BOOST) begin
      // B is always served on the first boosted cycle it still requests,
      // so BOOST lasts one cycle unless B withdrew first.
      if (b_gnt || !b_req) begin
        state_d = ST_NORMAL;
      end
    end else begin
      if (b_req && !b_gnt && (wait_cnt_q == WAIT_LAST)) begin
        state_d = ST_BOOST;
      end
    end

    if (b_req && !b_gnt) begin
      wait_cnt_d = wait_sat_inc(wait_cnt_q);
    end else begin
      wait_cnt_d = '0;
    end

    // Remember who owns the RAM read that completes at the next edge.
    a_rd_p1_d = a_gnt & ~a_we;
    b_rd_p1_d = b_gnt & ~b_we;

    last_addr_d = last_addr_q;
    if (a_gnt) begin
      last_addr_d = a_addr;
    end else if (b_gnt) begin
      last_addr_d = b_addr;
    end
  end

  // Control state: mode, aging counter and read-owner flags, cleared in reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_NORMAL;
      wait_cnt_q <= '0;
      a_rd_p1_q  <= 1'b0;
      b_rd_p1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      a_rd_p1_q  <= a_rd_p1_d;
      b_rd_p1_q  <= b_rd_p1_d;
    end
  end

  // Parked idle address; pure data, so it carries no reset.
  always_ff @(posedge clk) begin
    last_addr_q <= last_addr_d;
  end

  // Read return. The owner flag is masked by reset_n so a read issued just
  // before reset asserts is never reported, even in the reset cycle itself.
  assign a_rvalid = a_rd_p1_q & reset_n;
  assign b_rvalid = b_rd_p1_q & reset_n;

  // RAM output is shared; each requester qualifies it with its own rvalid.
  assign a_rdata = ram_dataOut;
  assign b_rdata = ram_dataOut;

endmodule

// File: tb/tb_grid_ram_arbiter.sv
// tb_grid_ram_arbiter
// Directed scenarios followed by randomized traffic, checked against a
// behavioural model built from the arbitration rules: B wins when it has been
// denied MAX_WAIT cycles in a row (or A is idle), otherwise A wins; reads
// return the model memory contents one cycle after the grant.

module tb_grid_ram_arbiter;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          ram_wEn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataIn, ram_dataOut;

  always #5 clk = ~clk;

  grid_ram_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .MAX_WAIT     (MW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .a_req      (a_req),
    .a_we       (a_we),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_gnt      (a_gnt),
    .a_rvalid   (a_rvalid),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_gnt      (b_gnt),
    .b_rvalid   (b_rvalid),
    .b_rdata    (b_rdata),
    .ram_wEn    (ram_wEn),
    .ram_addr   (ram_addr),
    .ram_dataIn (ram_dataIn),
    .ram_dataOut(ram_dataOut)
  );

  // Registered-read single-port RAM (16 words used), with a preload port.
  logic [DW-1:0] ram_mem [0:15];
  logic          pl_en;
  logic [3:0]    pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) ram_mem[pl_addr] <= pl_data;
    else if (ram_wEn) ram_mem[ram_addr[3:0]] <= ram_dataIn;
    ram_dataOut <= ram_mem[ram_addr[3:0]];
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:15];
  int            streak;
  logic          pend_a, pend_b;
  logic [DW-1:0] pend_da, pend_db;
  logic          has_last;
  logic [AW-1:0] last_addr;
  logic          gnt_a_last, gnt_b_last;

  // Observations of the most recent cycle for directed checks
  logic          obs_a, obs_b, obs_arv, obs_brv;
  logic [DW-1:0] obs_ard, obs_brd;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // One clock cycle: check outputs at negedge against the model, then advance.
  task automatic cyc();
    logic          ea, eb, ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    @(negedge clk);
    if (!reset_n) begin
      ea = 1'b0;
      eb = 1'b0;
    end else begin
      eb = b_req && (!a_req || streak >= MW);
      ea = a_req && !eb;
    end
    chk_val("a_gnt", a_gnt, ea);
    chk_val("b_gnt", b_gnt, eb);
    ewe   = ea ? a_we : (eb ? b_we : 1'b0);
    eaddr = ea ? a_addr : b_addr;
    ewd   = ea ? a_wdata : b_wdata;
    chk_val("ram_wEn", ram_wEn, ewe);
    if (ea || eb) begin
      chk_val("ram_addr", ram_addr, eaddr);
      chk_val("ram_dataIn", ram_dataIn, ewd);
    end else begin
      chk_val("ram_dataIn_idle", ram_dataIn, 0);
      if (has_last) chk_val("ram_addr_idle", ram_addr, last_addr);
    end
    chk_val("a_rvalid", a_rvalid, reset_n && pend_a);
    if (reset_n && pend_a) chk_val("a_rdata", a_rdata, pend_da);
    chk_val("b_rvalid", b_rvalid, reset_n && pend_b);
    if (reset_n && pend_b) chk_val("b_rdata", b_rdata, pend_db);

    obs_a = a_gnt;  obs_b = b_gnt;
    obs_arv = a_rvalid; obs_ard = a_rdata;
    obs_brv = b_rvalid; obs_brd = b_rdata;

    if (!reset_n) begin
      streak = 0;
      pend_a = 1'b0;
      pend_b = 1'b0;
    end else begin
      pend_a = ea && !a_we;
      pend_b = eb && !b_we;
      if (pend_a) pend_da = ref_mem[a_addr[3:0]];
      if (pend_b) pend_db = ref_mem[b_addr[3:0]];
      if (ea && a_we) ref_mem[a_addr[3:0]] = a_wdata;
      if (eb && b_we) ref_mem[b_addr[3:0]] = b_wdata;
      if (ea || eb) begin
        has_last  = 1'b1;
        last_addr = eaddr;
      end
      streak = (b_req && !eb) ? streak + 1 : 0;
    end
    gnt_a_last = ea;
    gnt_b_last = eb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a_rate;
    reset_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    streak = 0; pend_a = 1'b0; pend_b = 1'b0; pend_da = '0; pend_db = '0;
    has_last = 1'b0; last_addr = '0; gnt_a_last = 1'b0; gnt_b_last = 1'b0;

    // Preload RAM and model with 10+i while held in reset
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      pl_en = 1'b1; pl_addr = 4'(i); pl_data = DW'(10 + i);
      ref_mem[i] = DW'(10 + i);
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    // T1: requests during reset are ignored
    a_req = 1'b1; b_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk_val("t1_a_gnt", obs_a, 0);
      chk_val("t1_b_gnt", obs_b, 0);
      chk_val("t1_a_rvalid", obs_arv, 0);
    end
    a_req = 1'b0; b_req = 1'b0; reset_n = 1'b1;
    cyc();

    // T2: A write then read of addr 5
    a_req = 1'b1; a_we = 1'b1; a_addr = AW'(5); a_wdata = 32'h12345678;
    cyc();
    chk_val("t2_wr_gnt", obs_a, 1);
    a_we = 1'b0;
    cyc();
    chk_val("t2_rd_gnt", obs_a, 1);
    a_req = 1'b0;
    cyc();
    chk_val("t2_a_rvalid", obs_arv, 1);
    chk_val("t2_a_rdata", obs_ard, 32'h12345678);
    chk_val("t2_b_rvalid", obs_brv, 0);

    // T3: sustained contention, B served at cycle 8 exactly
    a_req = 1'b1; a_we = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = AW'(7);
    for (int c = 0; c < 10; c++) begin
      a_addr = AW'(c % 16);
      cyc();
      chk_val($sformatf("t3_a_gnt_c%0d", c), obs_a, c != 8);
      chk_val($sformatf("t3_b_gnt_c%0d", c), obs_b, c == 8);
      if (obs_b) b_req = 1'b0;
    end
    a_req = 1'b0; b_req = 1'b0;
    cyc();

    // T4: simultaneous writes to addr 3, A first, B next cycle
    a_req = 1'b1; a_we = 1'b1; a_addr = AW'(3); a_wdata = 32'hAA;
    b_req = 1'b1; b_we = 1'b1; b_addr = AW'(3); b_wdata = 32'hBB;
    cyc();
    chk_val("t4_a_first", obs_a, 1);
    chk_val("t4_b_denied", obs_b, 0);
    a_req = 1'b0;
    cyc();
    chk_val("t4_b_next", obs_b, 1);
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0;
    cyc();
    a_req = 1'b0;
    cyc();
    chk_val("t4_rvalid", obs_arv, 1);
    chk_val("t4_rdata", obs_ard, 32'hBB);

    // T5: B back-to-back reads of 0,1,2
    b_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_req = (i < 3);
      b_addr = AW'(i % 3);
      cyc();
      if (i > 0) begin
        chk_val($sformatf("t5_b_rvalid_%0d", i), obs_brv, 1);
        chk_val($sformatf("t5_b_rdata_%0d", i), obs_brd, 10 + i - 1);
      end
    end
    b_req = 1'b0;
    cyc();
    chk_val("t5_b_rvalid_end", obs_brv, 0);

    // T6: reset right after an A read grant suppresses its rvalid
    a_req = 1'b1; a_we = 1'b0; a_addr = AW'(1);
    cyc();
    chk_val("t6_gnt", obs_a, 1);
    a_req = 1'b0; reset_n = 1'b0;
    cyc();
    chk_val("t6_rvalid_in_reset", obs_arv, 0);
    reset_n = 1'b1;
    cyc();
    chk_val("t6_rvalid_after", obs_arv, 0);
    chk_val("t6_wait_cnt", dut.wait_cnt_q, 0);
    chk_val("t6_state", dut.state_q, 0);

    // Randomized traffic; heavy A load first so boosting is exercised
    for (int n = 0; n < 3000; n++) begin
      a_rate = (n < 1500) ? 9 : 6;
      if (!a_req || gnt_a_last) begin
        a_req   = ($urandom_range(0, 9) < a_rate);
        a_we    = 1'($urandom_range(0, 1));
        a_addr  = AW'($urandom_range(0, 15));
        a_wdata = $urandom;
      end
      if (!b_req || gnt_b_last) begin
        b_req   = ($urandom_range(0, 9) < 5);
        b_we    = 1'($urandom_range(0, 1));
        b_addr  = AW'($urandom_range(0, 15));
        b_wdata = $urandom;
      end else if ($urandom_range(0, 19) == 0) begin
        b_req = 1'b0;
      end
      reset_n = ($urandom_range(0, 99) != 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
